// File: rtl/vga_rx_timing.sv
// VGA receive timing recovery: rebuilds h/v counters from sync edges,
// checks line/frame periods, locks, then emits coordinates and colour.
module vga_rx_timing #(
  parameter int PIXEL_BITS     = 4,
  parameter int H_COUNT_MAX    = 800,
  parameter int V_COUNT_MAX    = 525,
  parameter int H_BITS         = $clog2(H_COUNT_MAX),
  parameter int V_BITS         = $clog2(V_COUNT_MAX),
  parameter int H_ACTIVE_START = 144,
  parameter int H_ACTIVE       = 640,
  parameter int V_ACTIVE_START = 35,
  parameter int V_ACTIVE       = 480,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pix_en,
  input  logic                  h_sync,
  input  logic                  v_sync,
  input  logic [PIXEL_BITS-1:0] vga_r_in,
  input  logic [PIXEL_BITS-1:0] vga_g_in,
  input  logic [PIXEL_BITS-1:0] vga_b_in,
  output logic [PIXEL_BITS-1:0] rx_r,
  output logic [PIXEL_BITS-1:0] rx_g,
  output logic [PIXEL_BITS-1:0] rx_b,
  output logic [H_BITS-1:0]     rx_x,
  output logic [V_BITS-1:0]     rx_y,
  output logic                  rx_active,
  output logic                  pix_valid,
  output logic                  line_start,
  output logic                  frame_start,
  output logic                  locked,
  output logic                  sync_err,
  output logic [H_BITS:0]       h_total,
  output logic [V_BITS:0]       v_total
);

  localparam logic [1:0] S_SEARCH = 2'd0;
  localparam logic [1:0] S_TRACK  = 2'd1;
  localparam logic [1:0] S_LOCKED = 2'd2;

  localparam int G_BITS = $clog2(LOCK_FRAMES + 1);
  localparam int H_END  = H_ACTIVE_START + H_ACTIVE;
  localparam int V_END  = V_ACTIVE_START + V_ACTIVE;

  localparam logic [H_BITS-1:0] H_SAT  = '1;
  localparam logic [V_BITS-1:0] V_SAT  = '1;
  localparam logic [H_BITS:0]   H_NOM  = (H_BITS+1)'(H_COUNT_MAX);
  localparam logic [V_BITS:0]   V_NOM  = (V_BITS+1)'(V_COUNT_MAX);
  localparam logic [H_BITS:0]   H_A0   = (H_BITS+1)'(H_ACTIVE_START);
  localparam logic [H_BITS:0]   H_A1   = (H_BITS+1)'(H_END);
  localparam logic [V_BITS:0]   V_A0   = (V_BITS+1)'(V_ACTIVE_START);
  localparam logic [V_BITS:0]   V_A1   = (V_BITS+1)'(V_END);
  localparam logic [H_BITS-1:0] H_X0   = H_BITS'(H_ACTIVE_START);
  localparam logic [V_BITS-1:0] V_Y0   = V_BITS'(V_ACTIVE_START);
  localparam logic [G_BITS-1:0] G_LOCK = G_BITS'(LOCK_FRAMES);

  logic              prev_h, prev_v;
  logic [H_BITS-1:0] h_cnt, h_nx;
  logic [V_BITS-1:0] v_cnt, v_nx;
  logic [H_BITS:0]   h_inc;
  logic [V_BITS:0]   v_inc;
  logic              h_seen, h_seen_nx;
  logic              line_bad, line_bad_nx;
  logic [1:0]        state, st_nx;
  logic [G_BITS-1:0] good_cnt, good_nx, good_inc;
  logic              h_fall, v_fall, h_sat, h_err, v_ok;
  logic              err, in_act, act;

  // Edge detect, counter next-state and period checks
  always_comb begin
    h_fall   = prev_h & ~h_sync;
    v_fall   = prev_v & ~v_sync;
    h_inc    = {1'b0, h_cnt} + (H_BITS+1)'(1);
    v_inc    = {1'b0, v_cnt} + (V_BITS+1)'(1);
    good_inc = good_cnt + G_BITS'(1);
    if (h_fall)              h_nx = '0;
    else if (h_cnt == H_SAT) h_nx = h_cnt;
    else                     h_nx = h_inc[H_BITS-1:0];
    if (v_fall)                       v_nx = '0;
    else if (h_fall && v_cnt != V_SAT) v_nx = v_inc[V_BITS-1:0];
    else                              v_nx = v_cnt;
    h_sat = ~h_fall & (h_nx == H_SAT);
    h_err = h_fall & h_seen & (h_inc != H_NOM);
    v_ok  = (v_inc == V_NOM);
  end

  // Lock FSM: SEARCH -> TRACK on frame edge, LOCKED after good frames
  always_comb begin
    st_nx       = state;
    good_nx     = good_cnt;
    err         = 1'b0;
    h_seen_nx   = h_seen | h_fall;
    line_bad_nx = line_bad;
    if (state != S_SEARCH && h_err) line_bad_nx = 1'b1;
    if (v_fall) line_bad_nx = 1'b0;
    case (state)
      S_SEARCH: begin
        if (v_fall) begin
          st_nx   = S_TRACK;
          good_nx = '0;
        end
      end
      S_TRACK: begin
        if (h_err) err = 1'b1;
        if (v_fall) begin
          if (line_bad | h_err | ~v_ok) begin
            good_nx = '0;
            err     = 1'b1;
          end else begin
            good_nx = good_inc;
            if (good_inc == G_LOCK) st_nx = S_LOCKED;
          end
        end
      end
      S_LOCKED: begin
        if (h_err | (v_fall & ~v_ok)) begin
          err     = 1'b1;
          st_nx   = S_TRACK;
          good_nx = '0;
        end
      end
      default: st_nx = S_SEARCH;
    endcase
    if (h_sat) begin
      st_nx     = S_SEARCH;
      good_nx   = '0;
      h_seen_nx = 1'b0;
    end
    in_act = ({1'b0, h_nx} >= H_A0) && ({1'b0, h_nx} < H_A1) &&
             ({1'b0, v_nx} >= V_A0) && ({1'b0, v_nx} < V_A1);
    act    = (st_nx == S_LOCKED) & in_act;
  end

  // Counter and FSM state, advanced only on pixel strobes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_h   <= 1'b1;
      prev_v   <= 1'b1;
      h_cnt    <= '0;
      v_cnt    <= '0;
      h_seen   <= 1'b0;
      line_bad <= 1'b0;
      state    <= S_SEARCH;
      good_cnt <= '0;
    end else if (pix_en) begin
      prev_h   <= h_sync;
      prev_v   <= v_sync;
      h_cnt    <= h_nx;
      v_cnt    <= v_nx;
      h_seen   <= h_seen_nx;
      line_bad <= line_bad_nx;
      state    <= st_nx;
      good_cnt <= good_nx;
    end
  end

  // Registered outputs; pulses only on strobe cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_r        <= '0;
      rx_g        <= '0;
      rx_b        <= '0;
      rx_x        <= '0;
      rx_y        <= '0;
      rx_active   <= 1'b0;
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      locked      <= 1'b0;
      sync_err    <= 1'b0;
      h_total     <= '0;
      v_total     <= '0;
    end else if (pix_en) begin
      rx_r        <= act ? vga_r_in : '0;
      rx_g        <= act ? vga_g_in : '0;
      rx_b        <= act ? vga_b_in : '0;
      rx_x        <= act ? h_nx - H_X0 : '0;
      rx_y        <= act ? v_nx - V_Y0 : '0;
      rx_active   <= act;
      pix_valid   <= act;
      line_start  <= h_fall;
      frame_start <= v_fall;
      locked      <= (st_nx == S_LOCKED);
      sync_err    <= err;
      if (h_fall) h_total <= h_inc;
      if (v_fall) v_total <= v_inc;
    end else begin
      pix_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      sync_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_rx_timing.sv
// Directed bench for vga_rx_timing on a reduced 20x12 raster
// driven by an in-bench sync generator.
module tb_vga_rx_timing;

  localparam int PB  = 4;
  localparam int HM  = 20;
  localparam int VM  = 12;
  localparam int HAS = 5;
  localparam int HA  = 10;
  localparam int VAS = 3;
  localparam int VA  = 6;
  localparam int LF  = 2;
  localparam int HB  = $clog2(HM);
  localparam int VB  = $clog2(VM);
  localparam int HS  = 3;
  localparam int VS  = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pix_en = 1'b0;
  logic          h_sync = 1'b1;
  logic          v_sync = 1'b1;
  logic [PB-1:0] vga_r_in = '0;
  logic [PB-1:0] vga_g_in = '0;
  logic [PB-1:0] vga_b_in = '0;
  logic [PB-1:0] rx_r, rx_g, rx_b;
  logic [HB-1:0] rx_x;
  logic [VB-1:0] rx_y;
  logic          rx_active, pix_valid, line_start, frame_start;
  logic          locked, sync_err;
  logic [HB:0]   h_total;
  logic [VB:0]   v_total;

  vga_rx_timing #(
    .PIXEL_BITS(PB), .H_COUNT_MAX(HM), .V_COUNT_MAX(VM),
    .H_ACTIVE_START(HAS), .H_ACTIVE(HA),
    .V_ACTIVE_START(VAS), .V_ACTIVE(VA), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en),
    .h_sync(h_sync), .v_sync(v_sync),
    .vga_r_in(vga_r_in), .vga_g_in(vga_g_in), .vga_b_in(vga_b_in),
    .rx_r(rx_r), .rx_g(rx_g), .rx_b(rx_b),
    .rx_x(rx_x), .rx_y(rx_y), .rx_active(rx_active),
    .pix_valid(pix_valid), .line_start(line_start),
    .frame_start(frame_start), .locked(locked), .sync_err(sync_err),
    .h_total(h_total), .v_total(v_total)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int gh = 0, gv = 0, pg = 0, pv = 0;
  int cnt_valid, cnt_fs, cnt_ls, cnt_err;
  int s_fs, s_ls, s_err, s_lk, s_act;

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic capture();
    s_fs  = int'(frame_start);
    s_ls  = int'(line_start);
    s_err = int'(sync_err);
    s_lk  = int'(locked);
    s_act = int'(rx_active);
    cnt_valid += int'(pix_valid);
    cnt_fs    += s_fs;
    cnt_ls    += s_ls;
    cnt_err   += s_err;
  endtask

  task automatic pix(input int gap, input bit on);
    int x, y;
    bit act;
    logic [PB-1:0] r, g, b;
    x   = gh - HAS;
    y   = gv - VAS;
    act = (gh >= HAS) && (gh < HAS + HA) && (gv >= VAS) && (gv < VAS + VA);
    r   = PB'(x);
    g   = PB'(y);
    b   = PB'(x ^ y);
    @(negedge clk);
    pix_en   = 1'b1;
    h_sync   = (gh >= HS);
    v_sync   = (gv >= VS);
    vga_r_in = r;
    vga_g_in = g;
    vga_b_in = b;
    @(posedge clk);
    #1;
    pg = gh;
    pv = gv;
    capture();
    if (on) begin
      chk("locked", s_lk, 1);
      chk("rx_active", s_act, int'(act));
      chk("pix_valid", int'(pix_valid), int'(act));
      chk("rx_x", int'(rx_x), act ? x : 0);
      chk("rx_y", int'(rx_y), act ? y : 0);
      chk("rx_r", int'(rx_r), act ? int'(r) : 0);
      chk("rx_g", int'(rx_g), act ? int'(g) : 0);
      chk("rx_b", int'(rx_b), act ? int'(b) : 0);
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      pix_en = 1'b0;
      @(posedge clk);
      #1;
      chk("quiet", int'({line_start, frame_start, sync_err, pix_valid}), 0);
      if (on) chk("hold_x", int'(rx_x), act ? x : 0);
    end
    gh++;
    if (gh == HM) begin
      gh = 0;
      gv++;
      if (gv == VM) gv = 0;
    end
  endtask

  task automatic extra_pix();
    @(negedge clk);
    pix_en   = 1'b1;
    h_sync   = 1'b1;
    v_sync   = (gv >= VS);
    vga_r_in = '0;
    vga_g_in = '0;
    vga_b_in = '0;
    @(posedge clk);
    #1;
    capture();
    @(negedge clk);
    pix_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input bit rnd, input bit on, input int stretch);
    cnt_valid = 0;
    cnt_fs    = 0;
    cnt_ls    = 0;
    cnt_err   = 0;
    do begin
      pix(rnd ? int'($urandom_range(5, 1)) : 1, on);
      if (stretch >= 0 && pg == 0 && pv == stretch + 1) begin
        chk("stretch_err", s_err, 1);
        chk("stretch_lock", s_lk, 0);
        chk("stretch_act", s_act, 0);
        chk("stretch_htot", int'(h_total), HM + 1);
      end
      if (stretch >= 0 && gh == 0 && gv == stretch + 1) extra_pix();
    end while (!(gh == 0 && gv == 0));
  endtask

  task automatic rst_chk();
    chk("rst_locked", int'(locked), 0);
    chk("rst_act", int'(rx_active), 0);
    chk("rst_xy", int'({rx_x, rx_y}), 0);
    chk("rst_rgb", int'({rx_r, rx_g, rx_b}), 0);
    chk("rst_pulses", int'({pix_valid, line_start, frame_start, sync_err}), 0);
    chk("rst_totals", int'({h_total, v_total}), 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst_chk();
    @(negedge clk);
    rst = 1'b0;

    // frame 1: first strobe sees both sync falls
    cnt_fs = 0; cnt_ls = 0; cnt_err = 0; cnt_valid = 0;
    pix(1, 0);
    chk("f1_fs", s_fs, 1);
    chk("f1_ls", s_ls, 1);
    chk("f1_lock", s_lk, 0);
    chk("f1_vtot", int'(v_total), 1);
    run_frame(0, 0, -1);
    chk("f1_ls_cnt", cnt_ls, VM - 1);
    chk("f1_htot", int'(h_total), HM);
    chk("f1_err", cnt_err, 0);

    // frame 2: still tracking
    run_frame(0, 0, -1);
    chk("f2_fs_cnt", cnt_fs, 1);
    chk("f2_lock", int'(locked), 0);
    chk("f2_vtot", int'(v_total), VM);

    // frame 3: locked from its first strobe, full pixel check
    run_frame(0, 1, -1);
    chk("f3_valid", cnt_valid, HA * VA);
    chk("f3_htot", int'(h_total), HM);
    chk("f3_vtot", int'(v_total), VM);

    // frame 4: random strobe gaps
    run_frame(1, 1, -1);
    chk("f4_valid", cnt_valid, HA * VA);
    chk("f4_err", cnt_err, 0);

    // frame 5: line 5 stretched by one strobe
    run_frame(0, 0, 5);
    chk("f5_err_cnt", cnt_err, 1);
    chk("f5_lock", int'(locked), 0);

    // frame 6 rejected for the bad line, 7 good, lock at 8
    run_frame(0, 0, -1);
    chk("f6_err_cnt", cnt_err, 1);
    chk("f6_lock", int'(locked), 0);
    run_frame(0, 0, -1);
    chk("f7_err_cnt", cnt_err, 0);
    chk("f7_lock", int'(locked), 0);
    run_frame(0, 1, -1);
    chk("f8_valid", cnt_valid, HA * VA);

    // hold syncs high until h counter saturates
    cnt_valid = 0; cnt_err = 0; cnt_fs = 0; cnt_ls = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pix_en = 1'b1;
      h_sync = 1'b1;
      v_sync = 1'b1;
      @(posedge clk);
      #1;
      capture();
      @(negedge clk);
      pix_en = 1'b0;
      @(posedge clk);
      #1;
    end
    chk("sat_lock", int'(locked), 0);
    chk("sat_valid", cnt_valid, 0);
    chk("sat_err", cnt_err, 0);

    // reacquire from SEARCH: lock only after the third frame edge
    pix(1, 0);
    chk("sat_htot", int'(h_total), 32);
    chk("f9_fs", s_fs, 1);
    chk("f9_lock", s_lk, 0);
    run_frame(0, 0, -1);
    run_frame(0, 0, -1);
    chk("f10_lock", int'(locked), 0);
    run_frame(0, 1, -1);
    chk("f11_valid", cnt_valid, HA * VA);

    // asynchronous reset mid-frame
    while (!(gh == 10 && gv == 5)) pix(1, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    rst_chk();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_frame(0, 0, -1);
    chk("rr_fs_cnt", cnt_fs, 0);
    chk("rr_ls_cnt", cnt_ls, VM - 6);
    chk("rr_err", cnt_err, 0);
    pix(1, 0);
    chk("rr_fs", s_fs, 1);
    chk("rr_lock", s_lk, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
